// File: rtl/your_design.sv
// Unsigned NxN iterative shift-add multiplier with a free-running
// LOAD -> MUL x N -> WRITE cycle. Y holds between updates and y_valid
// strobes for one cycle each time Y is rewritten.
module your_design #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic [2*N-1:0]   Y,
    output logic             y_valid
);

    localparam int unsigned W     = 2 * N;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_MUL   = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e           state_q;
    logic [W-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [W-1:0]     acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     y_q;
    logic             y_valid_q;

    // Sequencer and datapath: sample operands, accumulate one bit per cycle, publish result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    a_q     <= W'(A);
                    b_q     <= B;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    // Carry out of the 2N-bit add is always zero for unsigned NxN.
                    if (b_q[0]) begin
                        acc_q <= acc_q + a_q;
                    end
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    y_q       <= acc_q;
                    y_valid_q <= 1'b1;
                    state_q   <= S_LOAD;
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign Y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_your_design.sv
// Directed self-checking bench for the 4x4 shift-add multiplier.
module tb_your_design;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] Y;
    logic       y_valid;

    int errors = 0;
    int checks = 0;

    your_design #(.N(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .Y       (Y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance negedge by negedge until y_valid is seen or the budget runs out.
    task automatic wait_strobe(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!y_valid && n < max_cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        A = 4'b0010;
        B = 4'b1101;
        repeat (2) @(negedge clk);
        checks++;
        if (Y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", Y); end
        checks++;
        if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", y_valid); end
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (y_valid !== 1'b0) begin errors++; $display("FAIL early_valid: cycle %0d got %b expected 0", i, y_valid); end
        end
        @(negedge clk);
        checks++;
        if (y_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", y_valid); end
        checks++;
        if (Y !== 8'h1A) begin errors++; $display("FAIL first_y: got %h expected 1a", Y); end
        @(negedge clk);
        checks++;
        if (y_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_once: got %b expected 0", y_valid); end
    endtask

    // Operands already sampled at the LOAD edge; A changes during MUL.
    task automatic test_mid_change();
        int n;
        A = 4'b1010;
        wait_strobe(12, n);
        checks++;
        if (y_valid !== 1'b1 || Y !== 8'h1A) begin errors++; $display("FAIL midchg_current: got %h valid %b expected 1a valid 1", Y, y_valid); end
        wait_strobe(12, n);
        checks++;
        if (y_valid !== 1'b1 || Y !== 8'h82) begin errors++; $display("FAIL midchg_next: got %h valid %b expected 82 valid 1", Y, y_valid); end
        checks++;
        if (n != 6) begin errors++; $display("FAIL midchg_spacing: got %0d expected 6", n); end
    endtask

    task automatic test_sequential();
        int n;
        B = 4'b0110;
        wait_strobe(13, n);
        checks++;
        if (y_valid !== 1'b1 || Y !== 8'h3C) begin errors++; $display("FAIL seq_y: got %h valid %b expected 3c valid 1", Y, y_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (Y !== 8'h3C || y_valid !== 1'b0) begin errors++; $display("FAIL seq_hold: cycle %0d got %h valid %b expected 3c valid 0", i, Y, y_valid); end
        end
        wait_strobe(12, n);
        checks++;
        if (y_valid !== 1'b1 || Y !== 8'h3C || n != 1) begin errors++; $display("FAIL seq_rewrite: got %h valid %b after %0d expected 3c valid 1 after 1", Y, y_valid, n); end
    endtask

    task automatic test_boundaries();
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic [7:0] vy [4];
        int n;
        va[0] = 4'd15; vb[0] = 4'd15; vy[0] = 8'hE1;
        va[1] = 4'd0;  vb[1] = 4'd9;  vy[1] = 8'h00;
        va[2] = 4'd9;  vb[2] = 4'd0;  vy[2] = 8'h00;
        va[3] = 4'd1;  vb[3] = 4'd15; vy[3] = 8'h0F;
        for (int i = 0; i < 4; i++) begin
            A = va[i];
            B = vb[i];
            wait_strobe(12, n);
            checks++;
            if (y_valid !== 1'b1 || Y !== vy[i] || n != 6) begin
                errors++;
                $display("FAIL boundary_%0d: A=%0d B=%0d got %h valid %b after %0d expected %h valid 1 after 6",
                         i, va[i], vb[i], Y, y_valid, n, vy[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        A = 4'd7;
        B = 4'd11;
        repeat (3) @(negedge clk);
        checks++;
        if (Y !== 8'h0F) begin errors++; $display("FAIL midrst_hold: got %h expected 0f", Y); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (Y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL midrst_async: got %h valid %b expected 00 valid 0", Y, y_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(20, n);
        checks++;
        if (y_valid !== 1'b1 || Y !== 8'h4D || n != 6) begin errors++; $display("FAIL midrst_restart: got %h valid %b after %0d expected 4d valid 1 after 6", Y, y_valid, n); end
    endtask

    task automatic test_exhaustive();
        int n;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                A = 4'(a);
                B = 4'(b);
                wait_strobe(12, n);
                checks++;
                if (y_valid !== 1'b1 || Y !== 8'(a * b) || n != 6) begin
                    errors++;
                    $display("FAIL exhaustive: A=%0d B=%0d got %h valid %b after %0d expected %h valid 1 after 6",
                             a, b, Y, y_valid, n, 8'(a * b));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        A = '0;
        B = '0;
        test_reset();
        test_mid_change();
        test_sequential();
        test_boundaries();
        test_reset_mid_op();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
